// File: rtl/fft_deserializer.sv
// fft_deserializer
//   Collects a serial stream of real fixed-point samples into one parallel frame.
//   The frame is stored in bit-reversed slot order, so the first butterfly column
//   can pair adjacent slots (2k, 2k+1) directly. It uses a single frame buffer:
//   while a frame waits for downstream, no new samples are accepted.
//
// Parameters
//   BIT_WIDTH  width of one sample (stored bit-exact)
//   N_SAMPLES  samples per frame (power of two, >= 2)
//
// Ports
//   clk, reset : clock, synchronous active-high reset
//   recv_msg   : incoming sample
//   recv_val   : recv_msg valid
//   recv_rdy   : block can accept a sample (high while filling)
//   send_msg   : frame; slot k = bits [k*BIT_WIDTH +: BIT_WIDTH]
//   send_val   : frame valid (high while full)
//   send_rdy   : downstream accepts frame
module fft_deserializer #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH-1:0]           recv_msg,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  output logic [N_SAMPLES*BIT_WIDTH-1:0] send_msg,
  output logic                           send_val,
  input  logic                           send_rdy
);

  localparam int LOG2N = $clog2(N_SAMPLES);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_SAMPLES - 1);

  generate
    if (N_SAMPLES < 2 || (1 << LOG2N) != N_SAMPLES) begin : g_bad_param
      $error("fft_deserializer: N_SAMPLES must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [LOG2N-1:0]     cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] buf_q [N_SAMPLES];
  logic                 accept;

  // Reverse the LOG2N index bits of a sample position.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = idx[LOG2N-1-b];
    end
    return r;
  endfunction

  // Moore outputs: handshake outputs depend on state only.
  assign recv_rdy = (state_q == FILL);
  assign send_val = (state_q == FULL);
  assign accept   = recv_val && (state_q == FILL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          // Counter is exactly LOG2N bits, so the last accept wraps it to 0.
          cnt_d = cnt_q + LOG2N'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (send_rdy) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Buffer is written only while filling, so it holds steady while FULL.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_SAMPLES; k++) begin
        buf_q[k] <= '0;
      end
    end else if (accept) begin
      buf_q[bitrev(cnt_q)] <= recv_msg;
    end
  end

  generate
    for (genvar k = 0; k < N_SAMPLES; k++) begin : g_slot
      assign send_msg[k*BIT_WIDTH +: BIT_WIDTH] = buf_q[k];
    end
  endgenerate

endmodule
